// File: rtl/amo_controller.sv
// amo_controller: RV32A sequencer. Runs LR.W / SC.W / AMO*.W as a read-modify-write
// sequence on one req/gnt/rvalid data-memory port and holds the LR/SC reservation.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start, amo_op, rs1_val,       issue pulse (sampled in IDLE), one-hot op, word address,
//   rs2_val, rd_in                operand value, destination index
//   busy, done, illegal           status; done is a one-cycle pulse, illegal valid with done
//   rd_we, rd_waddr, rd_wdata     write-back to rd, valid with done
//   mem_req, mem_we, mem_addr,    memory request channel (held stable until gnt)
//   mem_wdata, mem_gnt
//   mem_rvalid, mem_rdata         read data / write ack
//   snoop_we, snoop_addr          store by another agent, clears a matching reservation
module amo_controller #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned RES_GRAN = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [8:0]      amo_op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic            illegal,
   output logic            rd_we,
   output logic [4:0]      rd_waddr,
   output logic [XLEN-1:0] rd_wdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            snoop_we,
   input  logic [XLEN-1:0] snoop_addr
);

   localparam int unsigned OP_W    = 9;
   localparam int unsigned GRAN_W  = XLEN - RES_GRAN;
   localparam int unsigned OP_LR   = 0;
   localparam int unsigned OP_SC   = 1;
   localparam int unsigned OP_SWAP = 2;
   localparam int unsigned OP_ADD  = 3;
   localparam int unsigned OP_AND  = 4;
   localparam int unsigned OP_OR   = 5;
   localparam int unsigned OP_XOR  = 6;
   localparam int unsigned OP_MAX  = 7;
   localparam int unsigned OP_MIN  = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RREQ  = 3'd1,
      RRESP = 3'd2,
      WREQ  = 3'd3,
      WRESP = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state;
   logic [OP_W-1:0]   op_q;
   logic [GRAN_W-1:0] addr_gran_q;
   logic [XLEN-1:0]   rs2_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_q;
   logic              res_valid;
   logic [GRAN_W-1:0] res_addr;

   logic [GRAN_W-1:0] rs1_gran_c;
   logic [GRAN_W-1:0] snoop_gran_c;
   logic              illegal_c;
   logic              sc_pass_c;
   logic              snoop_res_hit_c;
   logic              snoop_lr_hit_c;
   logic [XLEN-1:0]   amo_new_c;
   logic              unused_snoop_lsb_c;

   // Granule views and accept-time decisions
   assign rs1_gran_c      = rs1_val[XLEN-1:RES_GRAN];
   assign snoop_gran_c    = snoop_addr[XLEN-1:RES_GRAN];
   assign illegal_c       = (amo_op == '0) || ((amo_op & (amo_op - OP_W'(1))) != '0)
                            || (rs1_val[1:0] != 2'b00);
   assign snoop_res_hit_c = snoop_we && (snoop_gran_c == res_addr);
   assign snoop_lr_hit_c  = snoop_we && (snoop_gran_c == addr_gran_q);
   // A snoop to the SC address in the accept cycle kills the SC
   assign sc_pass_c       = res_valid && (res_addr == rs1_gran_c)
                            && !(snoop_we && (snoop_gran_c == rs1_gran_c));
   assign unused_snoop_lsb_c = ^snoop_addr[RES_GRAN-1:0];

   // New memory value for the AMO write, from the old value arriving on rvalid
   always_comb begin
      amo_new_c = rs2_q;
      if (op_q[OP_SWAP])     amo_new_c = rs2_q;
      else if (op_q[OP_ADD]) amo_new_c = mem_rdata + rs2_q;
      else if (op_q[OP_AND]) amo_new_c = mem_rdata & rs2_q;
      else if (op_q[OP_OR])  amo_new_c = mem_rdata | rs2_q;
      else if (op_q[OP_XOR]) amo_new_c = mem_rdata ^ rs2_q;
      else if (op_q[OP_MAX]) amo_new_c = ($signed(mem_rdata) > $signed(rs2_q)) ? mem_rdata : rs2_q;
      else if (op_q[OP_MIN]) amo_new_c = ($signed(mem_rdata) < $signed(rs2_q)) ? mem_rdata : rs2_q;
   end

   // Sequencer, reservation and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= '0;
         addr_gran_q <= '0;
         rs2_q       <= '0;
         result_q    <= '0;
         rd_q        <= '0;
         res_valid   <= 1'b0;
         res_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         rd_we       <= 1'b0;
         rd_waddr    <= '0;
         rd_wdata    <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         rd_we   <= 1'b0;
         if (snoop_res_hit_c) res_valid <= 1'b0;

         unique case (state)
            IDLE: begin
               if (start) begin
                  op_q        <= amo_op;
                  addr_gran_q <= rs1_gran_c;
                  rs2_q       <= rs2_val;
                  rd_q        <= rd_in;
                  busy        <= 1'b1;
                  if (illegal_c) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     illegal  <= 1'b1;
                     rd_waddr <= rd_in;
                     rd_wdata <= '0;
                  end else if (amo_op[OP_SC]) begin
                     res_valid <= 1'b0;
                     if (sc_pass_c) begin
                        state     <= WREQ;
                        result_q  <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= rs1_val;
                        mem_wdata <= rs2_val;
                     end else begin
                        state    <= DONE;
                        done     <= 1'b1;
                        rd_we    <= (rd_in != 5'd0);
                        rd_waddr <= rd_in;
                        rd_wdata <= XLEN'(1);
                     end
                  end else begin
                     state     <= RREQ;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_addr  <= rs1_val;
                     mem_wdata <= '0;
                  end
               end
            end
            RREQ: begin
               if (mem_gnt) begin
                  state   <= RRESP;
                  mem_req <= 1'b0;
               end
            end
            RRESP: begin
               if (mem_rvalid) begin
                  if (op_q[OP_LR]) begin
                     // Same-cycle snoop to the LR granule wins over the set
                     res_valid <= !snoop_lr_hit_c;
                     res_addr  <= addr_gran_q;
                     state     <= DONE;
                     done      <= 1'b1;
                     rd_we     <= (rd_q != 5'd0);
                     rd_waddr  <= rd_q;
                     rd_wdata  <= mem_rdata;
                  end else begin
                     result_q  <= mem_rdata;
                     state     <= WREQ;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_wdata <= amo_new_c;
                  end
               end
            end
            WREQ: begin
               if (mem_gnt) begin
                  state   <= WRESP;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            end
            WRESP: begin
               if (mem_rvalid) begin
                  if (!op_q[OP_SC] && (addr_gran_q == res_addr)) res_valid <= 1'b0;
                  state    <= DONE;
                  done     <= 1'b1;
                  rd_we    <= (rd_q != 5'd0);
                  rd_waddr <= rd_q;
                  rd_wdata <= result_q;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_amo_controller.sv
// tb_amo_controller: randomized bench for amo_controller with a transaction-level
// reference model (word memory + reservation) and a reactive memory responder.
module tb_amo_controller;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [8:0]  amo_op;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic        illegal;
   logic        rd_we;
   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        snoop_we;
   logic [31:0] snoop_addr;

   amo_controller #(.XLEN(32), .RES_GRAN(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .amo_op(amo_op),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
      .busy(busy), .done(done), .illegal(illegal), .rd_we(rd_we),
      .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .snoop_we(snoop_we), .snoop_addr(snoop_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Memory seen by the responder, and the model's view of it
   logic [31:0] phys_mem [256];
   logic [31:0] ref_mem  [256];
   bit          ref_res_v;
   logic [29:0] ref_res_a;

   // Responder knobs and bookkeeping
   int  gnt_lat  = 0;
   int  rv_lat   = 0;
   bit  rand_lat = 0;
   bit  noise    = 0;
   int  hs_count = 0;
   int  stab_err = 0;

   // Reactive memory: grants after a wait, answers after a delay, writes land at grant
   initial begin : responder
      bit          pend, gw_armed, prev_req, prev_gnt, p_write, p_we;
      int          gw, pdly;
      logic [7:0]  p_idx;
      logic [31:0] p_addr, p_wdata;
      pend = 0; gw_armed = 0; prev_req = 0; prev_gnt = 0; gw = 0; pdly = 0;
      p_write = 0; p_we = 0; p_idx = '0; p_addr = '0; p_wdata = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_gnt = 0;
         mem_rvalid = 0;
         if (!rst_n) begin
            pend = 0; gw_armed = 0; prev_req = 0; prev_gnt = 0;
         end else begin
            if (prev_req && !prev_gnt &&
                (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
               stab_err++;
            if (pend) begin
               if (pdly == 0) begin
                  mem_rvalid = 1;
                  mem_rdata  = p_write ? $urandom : phys_mem[p_idx];
                  pend = 0;
               end else pdly--;
            end else if (mem_req) begin
               if (!gw_armed) begin
                  gw = rand_lat ? int'($urandom_range(0, 3)) : gnt_lat;
                  gw_armed = 1;
               end
               if (gw == 0) begin
                  mem_gnt  = 1;
                  gw_armed = 0;
                  hs_count++;
                  pend     = 1;
                  p_write  = mem_we;
                  p_idx    = mem_addr[9:2];
                  pdly     = rand_lat ? int'($urandom_range(0, 3)) : rv_lat;
                  if (mem_we) phys_mem[p_idx] = mem_wdata;
               end else gw--;
            end else if (noise && !busy && $urandom_range(0, 3) == 0) begin
               mem_rvalid = 1;
               mem_rdata  = $urandom;
            end
            prev_req = mem_req; prev_gnt = mem_gnt;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
         end
      end
   end

   // Reference model of one accepted instruction; updates memory and reservation
   task automatic model_op(input logic [8:0] op, input logic [31:0] a, input logic [31:0] d,
                           output bit ill, output logic [31:0] data, output int lat,
                           output int hs);
      logic [31:0] old, nv;
      int idx;
      idx  = int'(a[9:2]);
      ill  = ($countones(op) != 1) || (a[1:0] != 2'b00);
      data = '0; lat = 1; hs = 0;
      if (ill) return;
      if (op[0]) begin
         data = ref_mem[idx]; ref_res_v = 1; ref_res_a = a[31:2]; lat = 3; hs = 1;
      end else if (op[1]) begin
         if (ref_res_v && ref_res_a == a[31:2]) begin
            ref_mem[idx] = d; data = 0; lat = 3; hs = 1;
         end else data = 1;
         ref_res_v = 0;
      end else begin
         old = ref_mem[idx];
         nv  = d;
         if (op[3]) nv = old + d;
         if (op[4]) nv = old & d;
         if (op[5]) nv = old | d;
         if (op[6]) nv = old ^ d;
         if (op[7]) nv = ($signed(old) > $signed(d)) ? old : d;
         if (op[8]) nv = ($signed(old) < $signed(d)) ? old : d;
         ref_mem[idx] = nv; data = old; lat = 5; hs = 2;
         if (ref_res_a == a[31:2]) ref_res_v = 0;
      end
   endtask

   logic [31:0] last_wdata;

   // Issue one instruction, wait for done, compare against the model
   task automatic run_op(input logic [8:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input bit chk_lat, input bit chaos);
      bit ill; logic [31:0] exp_data; int exp_lat, exp_hs, hs0, cyc;
      model_op(op, a, d, ill, exp_data, exp_lat, exp_hs);
      @(negedge clk);
      start = 1; amo_op = op; rs1_val = a; rs2_val = d; rd_in = rd;
      hs0 = hs_count;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!done && chaos) begin
            start   = ($urandom_range(0, 2) == 0);
            amo_op  = 9'($urandom);
            rs1_val = $urandom;
            rs2_val = $urandom;
            rd_in   = 5'($urandom);
         end else start = 0;
      end while (!done && cyc < 500);
      start = 0;
      last_wdata = rd_wdata;
      check_eq("done_seen", 32'(done), 1);
      check_eq("illegal", 32'(illegal), 32'(ill));
      check_eq("rd_we", 32'(rd_we), 32'(!ill && rd != 5'd0));
      check_eq("rd_waddr", 32'(rd_waddr), 32'(rd));
      if (!ill) check_eq("rd_wdata", rd_wdata, exp_data);
      check_eq("busy_in_done", 32'(busy), 1);
      if (chk_lat) check_eq("latency", 32'(cyc), 32'(exp_lat));
      check_eq("mem_handshakes", 32'(hs_count - hs0), 32'(exp_hs));
      check_eq("mem_word", phys_mem[a[9:2]], ref_mem[a[9:2]]);
      @(negedge clk);
      check_eq("done_one_cycle", 32'({done, busy}), 0);
   endtask

   task automatic snoop(input logic [31:0] a);
      @(negedge clk);
      snoop_we = 1; snoop_addr = a;
      if (ref_res_v && ref_res_a == a[31:2]) ref_res_v = 0;
      @(negedge clk);
      snoop_we = 0;
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] v);
      phys_mem[a[9:2]] = v;
      ref_mem[a[9:2]]  = v;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_ctrl"}, 32'({busy, done, illegal, rd_we, mem_req, mem_we}), 0);
      check_eq({tag, "_mem_addr"}, mem_addr, 0);
      check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
      check_eq({tag, "_rd"}, {rd_wdata[26:0], rd_waddr}, 0);
   endtask

   localparam logic [8:0] LR = 9'h001, SC = 9'h002, SWAP = 9'h004, ADD = 9'h008;
   localparam logic [8:0] MAX = 9'h080, MIN = 9'h100;

   initial begin : main
      int sel, hs0, cyc;
      bit force_sc, ill;
      logic [31:0] a, last_lr, dd;
      logic [8:0] op;
      int lat, hs;

      rst_n = 0; start = 0; amo_op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
      snoop_we = 0; snoop_addr = '0;
      ref_res_v = 0; ref_res_a = '0;
      for (int i = 0; i < 256; i++) begin
         dd = $urandom;
         phys_mem[i] = dd;
         ref_mem[i]  = dd;
      end
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1;
      repeat (2) @(negedge clk);

      // LR returns memory data with minimum latency
      poke(32'h100, 32'hDEADBEEF);
      run_op(LR, 32'h100, 32'h0, 5'd5, 1, 0);
      check_eq("lr_value", last_wdata, 32'hDEADBEEF);
      // SC pass then SC fail
      run_op(SC, 32'h100, 32'h55, 5'd6, 1, 0);
      check_eq("sc_pass_result", last_wdata, 32'h0);
      check_eq("sc_pass_mem", phys_mem[8'h40], 32'h55);
      run_op(SC, 32'h100, 32'h77, 5'd6, 1, 0);
      check_eq("sc_fail_result", last_wdata, 32'h1);
      // Snoop within the granule kills the reservation; SC elsewhere fails
      run_op(LR, 32'h100, 32'h0, 5'd7, 1, 0);
      snoop(32'h102);
      run_op(SC, 32'h100, 32'h99, 5'd7, 1, 0);
      check_eq("sc_after_snoop", last_wdata, 32'h1);
      run_op(LR, 32'h100, 32'h0, 5'd7, 1, 0);
      run_op(SC, 32'h200, 32'h99, 5'd7, 1, 0);
      check_eq("sc_other_addr", last_wdata, 32'h1);
      // Signed max/min and wrapping add
      poke(32'h100, 32'hFFFFFFF0);
      run_op(MAX, 32'h100, 32'h5, 5'd8, 1, 0);
      check_eq("max_old", last_wdata, 32'hFFFFFFF0);
      check_eq("max_mem", phys_mem[8'h40], 32'h5);
      poke(32'h104, 32'hFFFFFFFF);
      run_op(ADD, 32'h104, 32'h1, 5'd9, 1, 0);
      check_eq("add_wrap_mem", phys_mem[8'h41], 32'h0);
      poke(32'h108, 32'hFFFFFFF0);
      run_op(MIN, 32'h108, 32'h5, 5'd0, 1, 0);
      check_eq("min_mem", phys_mem[8'h42], 32'hFFFFFFF0);
      // Slow grant and response, with start pulses while busy
      gnt_lat = 4; rv_lat = 3;
      run_op(SWAP, 32'h10C, 32'hA5A5_0F0F, 5'd10, 0, 1);
      gnt_lat = 0; rv_lat = 0;
      // Malformed op and misaligned address
      run_op(9'b000001100, 32'h100, 32'h1, 5'd11, 1, 0);
      run_op(LR, 32'h101, 32'h0, 5'd12, 1, 0);

      // Reset while the AMO write is outstanding
      run_op(LR, 32'h140, 32'h0, 5'd3, 1, 0);
      model_op(ADD, 32'h180, 32'h3, ill, dd, lat, hs);
      rv_lat = 6;
      @(negedge clk);
      start = 1; amo_op = ADD; rs1_val = 32'h180; rs2_val = 32'h3; rd_in = 5'd4;
      hs0 = hs_count;
      @(negedge clk);
      start = 0;
      cyc = 0;
      while (hs_count < hs0 + 2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("reach_wresp", 32'(hs_count - hs0), 2);
      @(negedge clk);
      #2 rst_n = 0;
      #1 check_idle_outputs("mid_reset");
      ref_res_v = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      rv_lat = 0;
      check_eq("amo_write_landed", phys_mem[8'h60], ref_mem[8'h60]);
      run_op(SC, 32'h140, 32'h1, 5'd3, 1, 0);
      check_eq("sc_after_reset", last_wdata, 32'h1);

      // Randomized traffic
      rand_lat = 1; noise = 1;
      force_sc = 0; last_lr = 32'h100;
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 3) == 0) snoop(32'h100 + 32'($urandom_range(0, 31)));
         a = 32'h100 + 32'(4 * $urandom_range(0, 7));
         sel = int'($urandom_range(0, 11));
         if (force_sc) begin
            op = SC; a = last_lr;
         end else if (sel <= 2) op = LR;
         else if (sel <= 5) op = SC;
         else if (sel <= 10) op = 9'(1) << $urandom_range(2, 8);
         else op = 9'($urandom);
         if ($urandom_range(0, 15) == 0) a = a + 32'($urandom_range(1, 3));
         force_sc = (op == LR) && ($urandom_range(0, 1) == 1);
         if (op == LR) last_lr = a;
         run_op(op, a, $urandom, 5'($urandom), 0, 1);
      end

      check_eq("req_stable", 32'(stab_err), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
